// File: rtl/cla_multiword_sequencer.sv
// Purpose: adds two WIDTH-bit operands by reusing one 4-bit carry-lookahead slice, one nibble per clock, LSB first.
// Latency: out_valid rises WIDTH/4 edges after the accept edge; accept-to-accept is at least WIDTH/4+2 edges.
// Backpressure: in_ready is low from accept until the result is taken; the result holds in DONE while out_ready is low.
module cla_multiword_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] nib_sum;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;  // c[i] is the carry into bit i of the slice; c[4] is the slice carry-out

  // Route the nibble selected by idx from the latched operands into the slice.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == IDX_W'(n)) begin
        nib_a = a_q[4*n +: 4];
        nib_b = b_q[4*n +: 4];
      end
    end
  end

  // Four-bit lookahead slice: every internal carry is a flat G|P&c expression, no ripple inside the nibble.
  always_comb begin
    g    = nib_a & nib_b;
    p    = nib_a ^ nib_b;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    nib_sum = p ^ c[3:0];
  end

  // Sequencer: accept in IDLE, one slice pass per RUN edge, hold the result in DONE until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
      idx       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            carry_q  <= ci;
            idx      <= '0;
            sum      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IDX_W'(n)) begin
              sum[4*n +: 4] <= nib_sum;
            end
          end
          carry_q <= c[4];
          idx     <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            // On the top nibble c[3] is the carry into bit WIDTH-1, so c[3]^c[4] is signed overflow.
            co        <= c[4];
            ovf       <= c[3] ^ c[4];
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Purpose: directed checks on a 16-bit sequencer plus streamed random traffic on 4- and 32-bit instances.
// Latency: driven at posedge+1 (directed) or at negedge (random); outputs sampled away from the rising edge.
// Backpressure: random in_valid gaps and out_ready stalls; every result is checked once against a reference queue.
module tb_cla_multiword_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   total = 0;
  int   nbad  = 0;

  // 16-bit instance for directed vectors
  logic        d_iv, d_ci, d_ordy;
  logic [15:0] d_a, d_b;
  logic        d_ir, d_ov, d_co, d_ovf, d_busy;
  logic [15:0] d_sum;

  cla_multiword_sequencer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_ir), .a(d_a), .b(d_b), .ci(d_ci),
    .out_valid(d_ov), .out_ready(d_ordy), .sum(d_sum), .co(d_co), .ovf(d_ovf), .busy(d_busy)
  );

  // 4-bit and 32-bit instances for random traffic (index 0 = 4-bit, 1 = 32-bit)
  logic        r_iv[2], r_ci[2], r_ordy[2];
  logic        r_ir[2], r_ov[2], r_co[2], r_ovf[2], r_busy[2];
  logic [31:0] r_sum[2];
  logic [3:0]  a4, b4, sum4;
  logic [31:0] a32, b32, sum32;
  logic        ir4, ov4, co4, ovf4, busy4;
  logic        ir32, ov32, co32, ovf32, busy32;

  cla_multiword_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(r_iv[0]), .in_ready(ir4), .a(a4), .b(b4), .ci(r_ci[0]),
    .out_valid(ov4), .out_ready(r_ordy[0]), .sum(sum4), .co(co4), .ovf(ovf4), .busy(busy4)
  );

  cla_multiword_sequencer #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(r_iv[1]), .in_ready(ir32), .a(a32), .b(b32), .ci(r_ci[1]),
    .out_valid(ov32), .out_ready(r_ordy[1]), .sum(sum32), .co(co32), .ovf(ovf32), .busy(busy32)
  );

  always_comb begin
    r_ir[0] = ir4;   r_ov[0] = ov4;   r_co[0] = co4;   r_ovf[0] = ovf4;   r_busy[0] = busy4;
    r_sum[0] = {28'd0, sum4};
    r_ir[1] = ir32;  r_ov[1] = ov32;  r_co[1] = co32;  r_ovf[1] = ovf32;  r_busy[1] = busy32;
    r_sum[1] = sum32;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one operation on the 16-bit instance and wait for its result (called at posedge+1).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic [15:0] es, input logic eco, input logic eovf, input string tag);
    int k;
    d_a = a; d_b = b; d_ci = ci; d_iv = 1'b1;
    chk({tag, ".in_ready"}, d_ir, 1);
    @(posedge clk); #1;
    d_iv = 1'b0;
    chk({tag, ".busy"}, d_busy, 1);
    k = 0;
    while (!d_ov && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, ".latency"}, k, 4);
    chk({tag, ".sum"}, d_sum, es);
    chk({tag, ".co"}, d_co, eco);
    chk({tag, ".ovf"}, d_ovf, eovf);
  endtask

  task automatic retire(input string tag);
    d_ordy = 1'b1;
    @(posedge clk); #1;
    d_ordy = 1'b0;
    chk({tag, ".ov_drop"}, d_ov, 0);
    chk({tag, ".idle_rdy"}, d_ir, 1);
    chk({tag, ".idle_busy"}, d_busy, 0);
  endtask

  task automatic drive_r(input int sel, input logic iv, input logic [31:0] va, input logic [31:0] vb,
                         input logic vc);
    r_iv[sel] = iv;
    r_ci[sel] = vc;
    if (sel == 0) begin
      a4 = va[3:0];
      b4 = vb[3:0];
    end else begin
      a32 = va;
      b32 = vb;
    end
  endtask

  // Producer and consumer for one random instance, both acting on the falling edge.
  task automatic rnd(input int sel, input int n);
    int          w;
    logic [32:0] mask;
    logic [32:0] exp_q[$];
    logic        eovf_q[$];
    logic [32:0] full, gotv;
    logic [31:0] va, vb;
    logic        vc, iv, rl, ordy, eo;
    int          sent, got, guard;
    string       tg;
    w = (sel == 0) ? 4 : 32;
    tg = (sel == 0) ? "rnd4" : "rnd32";
    mask = (33'd1 << w) - 33'd1;
    iv = 1'b0; rl = 1'b0; sent = 0; got = 0; guard = 0;
    va = '0; vb = '0; vc = 1'b0;
    while ((sent < n || got < n) && guard < 40000) begin
      @(negedge clk);
      guard++;
      if (iv && rl) begin
        full = {1'b0, va} + {1'b0, vb} + {32'd0, vc};
        eo = (va[w-1] == vb[w-1]) && (full[w-1] != va[w-1]);
        exp_q.push_back(full);
        eovf_q.push_back(eo);
        sent++;
        iv = 1'b0;
      end
      if (!iv && sent < n && $urandom_range(3) != 0) begin
        va = $urandom & mask[31:0];
        vb = $urandom & mask[31:0];
        if ($urandom_range(7) == 0) va = mask[31:0];
        if ($urandom_range(7) == 0) vb = mask[31:0] >> 1;
        vc = 1'($urandom_range(1));
        iv = 1'b1;
      end
      drive_r(sel, iv, va, vb, vc);
      rl = r_ir[sel];
      ordy = ($urandom_range(3) != 0);
      r_ordy[sel] = ordy;
      if (r_ov[sel] && ordy) begin
        if (exp_q.size() == 0) begin
          chk({tg, ".dup"}, 1, 0);
        end else begin
          gotv = ({32'd0, r_co[sel]} << w) | {1'b0, r_sum[sel]};
          chk({tg, ".co_sum"}, gotv, exp_q.pop_front());
          chk({tg, ".ovf"}, r_ovf[sel], eovf_q.pop_front());
          chk({tg, ".busy"}, r_busy[sel], 1);
        end
        got++;
      end
    end
    r_ordy[sel] = 1'b0;
    drive_r(sel, 1'b0, '0, '0, 1'b0);
    chk({tg, ".sent"}, sent, n);
    chk({tg, ".got"}, got, n);
    chk({tg, ".left"}, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    d_iv = 1'b0; d_ci = 1'b0; d_ordy = 1'b0; d_a = '0; d_b = '0;
    for (int s = 0; s < 2; s++) begin
      r_ordy[s] = 1'b0;
      drive_r(s, 1'b0, '0, '0, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", d_ir, 1);
    chk("rst.out_valid", d_ov, 0);
    chk("rst.busy", d_busy, 0);
    chk("rst.sum", d_sum, 0);
    chk("rst.co", d_co, 0);
    chk("rst.ovf", d_ovf, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Plain add, then hold the result under backpressure while junk arrives on the input side.
    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "t1");
    for (int i = 0; i < 10; i++) begin
      d_iv = i[0];
      d_a = 16'hA5A5 ^ 16'(i);
      d_b = 16'hFFFF;
      d_ci = 1'b1;
      @(posedge clk); #1;
      chk("t4.ov_hold", d_ov, 1);
      chk("t4.sum_hold", d_sum, 16'h5555);
      chk("t4.co_hold", d_co, 0);
      chk("t4.in_ready", d_ir, 0);
    end
    d_iv = 1'b0;
    retire("t4");
    repeat (3) begin
      @(posedge clk); #1;
      chk("t4.no_extra", d_ov, 0);
    end

    do_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "t2");
    retire("t2");
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "t3a");
    retire("t3a");
    do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "t3b");
    retire("t3b");

    // Abort an operation after two RUN edges.
    d_a = 16'hFFFF; d_b = 16'h0001; d_ci = 1'b0; d_iv = 1'b1;
    @(posedge clk); #1;
    d_iv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5.ov", d_ov, 0);
    chk("t5.sum", d_sum, 0);
    chk("t5.in_ready", d_ir, 1);
    chk("t5.busy", d_busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("t5.no_result", d_ov, 0);
    end
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "t5b");
    retire("t5b");

    fork
      rnd(0, 1000);
      rnd(1, 1000);
    join

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
